// File: rtl/core_pkg.sv
// Shared definitions for the core dispatcher: per-core status encoding,
// the dispatcher state set and a helper mapping a state to its status code.
package core_pkg;

    // Width of one core's status field
    localparam int STATUS_W = 2;

    localparam logic [STATUS_W-1:0] STATUS_IDLE  = 2'b00;
    localparam logic [STATUS_W-1:0] STATUS_START = 2'b01;
    localparam logic [STATUS_W-1:0] STATUS_RUN   = 2'b10;
    localparam logic [STATUS_W-1:0] STATUS_ACK   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Status code presented to an enabled core in a given dispatcher state.
    // DONE already shows IDLE so the cores see the run as finished.
    function automatic logic [STATUS_W-1:0] status_of(input state_e s);
        case (s)
            ST_START: return STATUS_START;
            ST_RUN:   return STATUS_RUN;
            ST_ACK:   return STATUS_ACK;
            default:  return STATUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Clear/enable up-counter that sticks at all-ones instead of wrapping.
// Clear has priority over enable.
module sat_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_dispatcher.sv
// Launches a set of cores through START and RUN, waits for all enabled
// cores to report completion (or timeout/abort), acknowledges them for one
// cycle and then pulses done with the run length and completion mask.
module core_dispatcher
    import core_pkg::*;
#(
    parameter int N_CORES      = 4,
    parameter int START_CYCLES = 2,
    parameter int CNT_W        = 24,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_CORES-1:0]            core_mask,
    input  logic                          abort,
    input  logic [N_CORES-1:0]            end_process,
    output logic [STATUS_W*N_CORES-1:0]   status,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout,
    output logic                          aborted,
    output logic [N_CORES-1:0]            done_mask,
    output logic [CNT_W-1:0]              run_cycles
);

    // Phase counter only needs to reach START_CYCLES-1; a zero or one
    // cycle START phase collapses to a single cycle.
    localparam int PH_W = (START_CYCLES > 2) ? $clog2(START_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST =
        PH_W'((START_CYCLES > 1) ? (START_CYCLES - 1) : 0);
    // The run counter is compared before it increments, so the timeout
    // fires in the RUN cycle that brings the count up to TIMEOUT.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e               state_q, state_d;
    logic [N_CORES-1:0]   mask_q, mask_d;
    logic [N_CORES-1:0]   fin_q, fin_d;
    logic [N_CORES-1:0]   done_mask_q, done_mask_d;
    logic                 timeout_q, timeout_d;
    logic                 aborted_q, aborted_d;

    logic                 accept;
    logic [N_CORES-1:0]   ep_masked;
    logic                 all_fin;
    logic                 ph_last;
    logic                 to_hit;
    logic [CNT_W-1:0]     run_cnt;
    logic [PH_W-1:0]      ph_cnt;
    logic [STATUS_W-1:0]  st_code;

    assign accept    = (state_q == ST_IDLE) && start;
    assign ep_masked = end_process & mask_q;
    assign all_fin   = ((fin_q | ep_masked) == mask_q);
    assign ph_last   = (ph_cnt == PH_LAST);
    assign to_hit    = TO_EN && (run_cnt == TO_LAST);

    // RUN-cycle counter; its value is the reported run length and it
    // holds after the run until the next accepted start.
    sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (state_q == ST_RUN),
        .cnt_o (run_cnt)
    );

    // Counts cycles spent in START
    sat_counter #(
        .W (PH_W)
    ) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (state_q == ST_START),
        .cnt_o (ph_cnt)
    );

    // Sequencing and per-run bookkeeping; abort beats completion, which
    // beats timeout.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        fin_d       = fin_q;
        done_mask_d = done_mask_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d      = core_mask;
                    fin_d       = '0;
                    done_mask_d = '0;
                    timeout_d   = 1'b0;
                    aborted_d   = 1'b0;
                    state_d     = (core_mask == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_ACK;
                end else if (ph_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fin_d = fin_q | ep_masked;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_ACK;
                end else if (all_fin) begin
                    state_d = ST_ACK;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                done_mask_d = fin_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and run bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            fin_q       <= '0;
            done_mask_q <= '0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            fin_q       <= fin_d;
            done_mask_q <= done_mask_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
        end
    end

    assign st_code = status_of(state_q);

    // Enabled cores follow the dispatcher state; the rest are held IDLE
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_status
        assign status[gi*STATUS_W +: STATUS_W] = mask_q[gi] ? st_code : STATUS_IDLE;
    end

    assign busy       = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_ACK);
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign aborted    = aborted_q;
    assign done_mask  = done_mask_q;
    assign run_cycles = run_cnt;

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher (START_CYCLES=2, TIMEOUT=20).
// Inputs change 1 time unit after the rising edge, outputs are checked there.
module tb_core_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  core_mask;
    logic        abort;
    logic [3:0]  end_process;
    logic [7:0]  status;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        aborted;
    logic [3:0]  done_mask;
    logic [23:0] run_cycles;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    core_dispatcher #(
        .N_CORES      (4),
        .START_CYCLES (2),
        .CNT_W        (24),
        .TIMEOUT      (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_mask   (core_mask),
        .abort       (abort),
        .end_process (end_process),
        .status      (status),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .aborted     (aborted),
        .done_mask   (done_mask),
        .run_cycles  (run_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and step through the two START cycles; returns in RUN cycle 1
    task automatic launch(input logic [3:0] m);
        start = 1'b1; core_mask = m;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_mask = '0; end_process = '0;
        tick(); tick();
        total++;
        if ({status, busy, done, timeout, aborted, done_mask, run_cycles} !== 40'd0) begin
            $display("FAIL reset_outputs got st=%h busy=%b done=%b to=%b ab=%b dm=%b rc=%0d want all 0",
                     status, busy, done, timeout, aborted, done_mask, run_cycles);
        end else passed++;
        rst_n = 1'b1;
        tick();
        total++;
        if ({status, busy, done} !== 10'd0) begin
            $display("FAIL reset_release got st=%h busy=%b done=%b want 00/0/0", status, busy, done);
        end else passed++;
        $display("reset: done");
    endtask

    task automatic test_two_cores();
        start = 1'b1; core_mask = 4'b0101;
        tick();
        start = 1'b0; core_mask = 4'b1111;   // mask change while busy must not matter
        total++;
        if ({status, busy} !== {8'h11, 1'b1}) begin
            $display("FAIL t1_start1 got st=%h busy=%b want 11/1", status, busy);
        end else passed++;
        tick();
        total++;
        if (status !== 8'h11) $display("FAIL t1_start2 got st=%h want 11", status);
        else passed++;
        tick();
        total++;
        if (status !== 8'h22) $display("FAIL t1_run1 got st=%h want 22", status);
        else passed++;
        for (int k = 1; k <= 7; k++) begin
            end_process = (k == 3) ? 4'b0001 : ((k == 7) ? 4'b0100 : 4'b0000);
            tick();
            if (k < 7) begin
                total++;
                if ({status, run_cycles} !== {8'h22, 24'(k)}) begin
                    $display("FAIL t1_run got st=%h rc=%0d want 22/%0d", status, run_cycles, k);
                end else passed++;
            end
        end
        end_process = '0;
        total++;
        if ({status, busy, done} !== {8'h33, 1'b1, 1'b0}) begin
            $display("FAIL t1_ack got st=%h busy=%b done=%b want 33/1/0", status, busy, done);
        end else passed++;
        tick();
        total++;
        if ({done, busy, timeout, aborted, done_mask, run_cycles, status} !==
            {4'b1000, 4'b0101, 24'd7, 8'h00}) begin
            $display("FAIL t1_done got d/b/t/a=%b%b%b%b dm=%b rc=%0d st=%h want 1000 0101 7 00",
                     done, busy, timeout, aborted, done_mask, run_cycles, status);
        end else passed++;
        tick();
        total++;
        if ({done, run_cycles} !== {1'b0, 24'd7}) begin
            $display("FAIL t1_after got done=%b rc=%0d want 0/7", done, run_cycles);
        end else passed++;
        $display("test 1 two cores: done");
    endtask

    task automatic test_masked_ignore();
        launch(4'b0001);
        for (int k = 1; k <= 5; k++) begin
            end_process = (k == 2) ? 4'b1000 : ((k == 5) ? 4'b0001 : 4'b0000);
            tick();
            if (k < 5) begin
                total++;
                if ({status, run_cycles} !== {8'h02, 24'(k)}) begin
                    $display("FAIL t2_run got st=%h rc=%0d want 02/%0d", status, run_cycles, k);
                end else passed++;
            end
        end
        end_process = '0;
        total++;
        if (status !== 8'h03) $display("FAIL t2_ack got st=%h want 03", status);
        else passed++;
        tick();
        total++;
        if ({done, done_mask, run_cycles} !== {1'b1, 4'b0001, 24'd5}) begin
            $display("FAIL t2_done got done=%b dm=%b rc=%0d want 1/0001/5", done, done_mask, run_cycles);
        end else passed++;
        tick();
        $display("test 2 masked end_process: done");
    endtask

    task automatic test_empty_mask();
        start = 1'b1; core_mask = 4'b0000;
        tick();
        start = 1'b0;
        total++;
        if ({done, busy, status, run_cycles, done_mask} !== {1'b1, 1'b0, 8'h00, 24'd0, 4'b0000}) begin
            $display("FAIL t3_done got done=%b busy=%b st=%h rc=%0d dm=%b want 1/0/00/0/0000",
                     done, busy, status, run_cycles, done_mask);
        end else passed++;
        tick();
        total++;
        if ({done, status} !== 9'd0) $display("FAIL t3_idle got done=%b st=%h want 0/00", done, status);
        else passed++;
        $display("test 3 empty mask: done");
    endtask

    task automatic test_timeout();
        launch(4'b1111);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10 || k == 19) begin
                total++;
                if ({status, run_cycles} !== {8'hAA, 24'(k)}) begin
                    $display("FAIL t4_run got st=%h rc=%0d want AA/%0d", status, run_cycles, k);
                end else passed++;
            end
        end
        total++;
        if ({status, run_cycles} !== {8'hFF, 24'd20}) begin
            $display("FAIL t4_ack got st=%h rc=%0d want FF/20", status, run_cycles);
        end else passed++;
        tick();
        total++;
        if ({done, busy, timeout, aborted, done_mask, run_cycles} !== {4'b1010, 4'b0000, 24'd20}) begin
            $display("FAIL t4_done got d/b/t/a=%b%b%b%b dm=%b rc=%0d want 1010/0000/20",
                     done, busy, timeout, aborted, done_mask, run_cycles);
        end else passed++;
        tick();
        $display("test 4 timeout: done");
    endtask

    task automatic test_abort();
        launch(4'b0011);
        end_process = 4'b0001;
        tick();
        total++;
        if (status !== 8'h0A) $display("FAIL t5_run2 got st=%h want 0A", status);
        else passed++;
        // final completion, abort and a second start all in the same cycle
        end_process = 4'b0010; abort = 1'b1; start = 1'b1; core_mask = 4'b1111;
        tick();
        end_process = '0; abort = 1'b0;
        total++;
        if ({status, busy} !== {8'h0F, 1'b1}) begin
            $display("FAIL t5_ack got st=%h busy=%b want 0F/1", status, busy);
        end else passed++;
        tick();   // start still high here: ignored in DONE
        total++;
        if ({done, busy, timeout, aborted, run_cycles} !== {4'b1001, 24'd2}) begin
            $display("FAIL t5_done got d/b/t/a=%b%b%b%b rc=%0d want 1001/2",
                     done, busy, timeout, aborted, run_cycles);
        end else passed++;
        tick();   // IDLE: start sampled here
        total++;
        if ({done, busy, status} !== 10'd0) begin
            $display("FAIL t5_idle got done=%b busy=%b st=%h want 0/0/00", done, busy, status);
        end else passed++;
        tick();
        start = 1'b0;
        total++;
        if ({status, busy, aborted, run_cycles} !== {8'h55, 1'b1, 1'b0, 24'd0}) begin
            $display("FAIL t5_restart got st=%h busy=%b ab=%b rc=%0d want 55/1/0/0",
                     status, busy, aborted, run_cycles);
        end else passed++;
        $display("test 5 abort and restart: done");
    endtask

    // Continues the run left in START by test_abort
    task automatic test_async_reset();
        tick(); tick(); tick(); tick();
        total++;
        if ({status, busy, run_cycles} !== {8'hAA, 1'b1, 24'd2}) begin
            $display("FAIL t6_run got st=%h busy=%b rc=%0d want AA/1/2", status, busy, run_cycles);
        end else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({status, busy, done, run_cycles} !== 34'd0) begin
            $display("FAIL t6_async got st=%h busy=%b done=%b rc=%0d want 00/0/0/0",
                     status, busy, done, run_cycles);
        end else passed++;
        tick(); tick();
        total++;
        if ({done, busy, status} !== 10'd0) $display("FAIL t6_held got done=%b busy=%b st=%h want 0", done, busy, status);
        else passed++;
        rst_n = 1'b1;
        tick();
        launch(4'b0010);
        end_process = 4'b0010;
        tick();
        end_process = '0;
        total++;
        if (status !== 8'h0C) $display("FAIL t6_ack got st=%h want 0C", status);
        else passed++;
        tick();
        total++;
        if ({done, timeout, aborted, done_mask, run_cycles} !== {3'b100, 4'b0010, 24'd1}) begin
            $display("FAIL t6_done got d/t/a=%b%b%b dm=%b rc=%0d want 100/0010/1",
                     done, timeout, aborted, done_mask, run_cycles);
        end else passed++;
        tick();
        $display("test 6 async reset: done");
    endtask

    initial begin
        test_reset();
        test_two_cores();
        test_masked_ignore();
        test_empty_mask();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
